dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 24 ++
 rtl/dmem_bram.sv | 42 ++++
 rtl/dmem_responder.sv | 118 +++++++++++
 tb/tb_dmem_responder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } state_t;

    // Expands byte enables into a per-bit write mask.
    function automatic logic [DATA_W-1:0] be_mask(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < int'(BE_W); i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_bram.sv
// Word-organised storage: synchronous byte-enabled write, combinational read.
module dmem_bram
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 48
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] rdata_c
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] mask;

    assign in_range = 32'(addr) < DEPTH;
    assign idx      = IDX_W'(addr);
    assign mask     = be_mask(be);

    // Merge enabled bytes into the addressed word; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (wr_en && in_range) begin
            mem[idx] <= (mem[idx] & ~mask) | (wdata & mask);
        end
    end

    // Unimplemented words read as zero.
    always_comb begin
        rdata_c = '0;
        if (in_range) begin
            rdata_c = mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// CPU data-bus responder with programmable wait states in front of a small RAM.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned DEPTH    = 48,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam int unsigned CNT_W = 4;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic                cap_we;
    logic [ADDR_W-1:0]   cap_addr;
    logic [DATA_W-1:0]   cap_wdata;
    logic [BE_W-1:0]     cap_be;
    logic                cap_in_range;
    logic                in_resp;
    logic                mem_wr;
    logic [DATA_W-1:0]   mem_rdata;

    assign cap_in_range = 32'(cap_addr) < DEPTH;
    assign in_resp      = (state == RESP);
    assign mem_wr       = in_resp && cap_we && cap_in_range;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; HOLD blocks a stale req from starting a second transfer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = (WAIT_CYC == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt <= CNT_W'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: state_next = HOLD;
            HOLD: begin
                if (!req) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request capture and wait-state counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
        end else begin
            if (state == IDLE && req) begin
                cnt       <= CNT_W'(WAIT_CYC);
                cap_we    <= we;
                cap_addr  <= addr;
                cap_wdata <= wdata;
                cap_be    <= be;
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    // Completion outputs, registered at the edge that ends RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            ack   <= in_resp;
            err   <= in_resp && !cap_in_range;
            rdata <= (in_resp && !cap_we && cap_in_range) ? mem_rdata : '0;
        end
    end

    dmem_bram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_bram (
        .clk     (clk),
        .wr_en   (mem_wr),
        .addr    (cap_addr),
        .wdata   (cap_wdata),
        .be      (cap_be),
        .rdata_c (mem_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;

    localparam int unsigned AW    = 6;
    localparam int unsigned DEPTH = 48;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req = 1'b0, we = 1'b0;
    logic [5:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        ack, err;
    logic [31:0] rdata;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [5:0]  addr0 = '0;
    logic [31:0] wdata0 = '0;
    logic [3:0]  be0 = '0;
    logic        ack0, err0;
    logic [31:0] rdata0;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [DEPTH];

    dmem_responder #(.ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYC(2)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .be(be), .ack(ack), .rdata(rdata), .err(err)
    );

    dmem_responder #(.ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .be(be0), .ack(ack0), .rdata(rdata0), .err(err0)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic model_apply(input logic w, input logic [5:0] a, input logic [31:0] d,
                               input logic [3:0] b);
        if (w && a < DEPTH) model[a] = merge(model[a], d, b);
    endtask

    function automatic logic [31:0] exp_rd(input logic w, input logic [5:0] a);
        return (!w && a < DEPTH) ? model[a] : 32'h0;
    endfunction

    // One bus transfer on the WAIT_CYC=2 instance; lat = edges after the sampling edge.
    task automatic txn(input logic w, input logic [5:0] a, input logic [31:0] d,
                       input logic [3:0] b, output logic [31:0] rd, output logic er,
                       output int lat);
        rd = '0; er = 1'b0; lat = -1;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ack) begin lat = n; rd = rdata; er = err; break; end
        end
        req = 1'b0; we = 1'($urandom); addr = 6'($urandom); wdata = $urandom; be = 4'($urandom);
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL txn_timeout addr=%0d: no ack within 40 cycles", a);
        end
    endtask

    // Same transfer on the zero-wait instance.
    task automatic txn0(input logic w, input logic [5:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] rd, output logic er,
                        output int lat);
        rd = '0; er = 1'b0; lat = -1;
        @(negedge clk);
        req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; be0 = b;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ack0) begin lat = n; rd = rdata0; er = err0; break; end
        end
        req0 = 1'b0;
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL txn0_timeout addr=%0d: no ack within 40 cycles", a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++; if (ack !== 1'b0)     begin errors++; $display("FAIL reset_ack got=%b exp=0", ack); end
        checks++; if (err !== 1'b0)     begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (rdata !== 32'h0)  begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        checks++; if (ack0 !== 1'b0)    begin errors++; $display("FAIL reset_ack0 got=%b exp=0", ack0); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (ack !== 1'b0)     begin errors++; $display("FAIL idle_ack got=%b exp=0", ack); end
    endtask

    task automatic test_init();
        logic [31:0] rd, d; logic er; int lat;
        for (int a = 0; a < int'(DEPTH); a++) begin
            d = $urandom;
            txn(1'b1, 6'(a), d, 4'hF, rd, er, lat);
            model_apply(1'b1, 6'(a), d, 4'hF);
            checks++; if (lat != 3)   begin errors++; $display("FAIL init_lat addr=%0d got=%0d exp=3", a, lat); end
            checks++; if (er !== 1'b0) begin errors++; $display("FAIL init_err addr=%0d got=%b exp=0", a, er); end
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er; int lat;
        txn(1'b1, 6'd5, 32'hDEADBEEF, 4'hF, rd, er, lat);
        model_apply(1'b1, 6'd5, 32'hDEADBEEF, 4'hF);
        checks++; if (lat != 3)    begin errors++; $display("FAIL wr_lat got=%0d exp=3", lat); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err got=%b exp=0", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata got=%h exp=0", rd); end
        txn(1'b0, 6'd5, 32'h0, 4'h0, rd, er, lat);
        checks++; if (lat != 3)    begin errors++; $display("FAIL rd_lat got=%0d exp=3", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err got=%b exp=0", er); end
        @(negedge clk);
        checks++; if (ack !== 1'b0 || rdata !== 32'h0)
            begin errors++; $display("FAIL post_ack got ack=%b rdata=%h exp 0/0", ack, rdata); end
    endtask

    task automatic test_byte_enables();
        logic [31:0] rd; logic er; int lat;
        txn(1'b1, 6'd3, 32'h11223344, 4'hF, rd, er, lat); model_apply(1'b1, 6'd3, 32'h11223344, 4'hF);
        txn(1'b1, 6'd3, 32'hAABBCCDD, 4'h5, rd, er, lat); model_apply(1'b1, 6'd3, 32'hAABBCCDD, 4'h5);
        txn(1'b0, 6'd3, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL be_merge got=%h exp=11bb33dd", rd); end
        txn(1'b1, 6'd3, 32'hFFFFFFFF, 4'h0, rd, er, lat);
        checks++; if (lat != 3 || er !== 1'b0)
            begin errors++; $display("FAIL be0_complete got lat=%0d err=%b exp 3/0", lat, er); end
        txn(1'b0, 6'd3, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL be0_unchanged got=%h exp=11bb33dd", rd); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic er; int lat;
        txn(1'b1, 6'd50, 32'hCAFEF00D, 4'hF, rd, er, lat);
        checks++; if (er !== 1'b1 || lat != 3)
            begin errors++; $display("FAIL oor_wr got err=%b lat=%0d exp 1/3", er, lat); end
        txn(1'b0, 6'd50, 32'h0, 4'h0, rd, er, lat);
        checks++; if (er !== 1'b1)  begin errors++; $display("FAIL oor_rd_err got=%b exp=1", er); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rd_data got=%h exp=0", rd); end
        for (int a = 0; a < int'(DEPTH); a++) begin
            txn(1'b0, 6'(a), 32'h0, 4'h0, rd, er, lat);
            checks++; if (rd !== model[a])
                begin errors++; $display("FAIL oor_scan addr=%0d got=%h exp=%h", a, rd, model[a]); end
        end
    endtask

    task automatic test_capture();
        logic [31:0] rd, got; logic er; int lat; int nacks;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 6'd9; wdata = '0; be = '0;
        @(negedge clk);
        we = 1'b1; addr = 6'd10; wdata = ~model[10]; be = 4'hF;
        nacks = 0; got = '0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (ack) begin nacks++; got = rdata; req = 1'b0; end
        end
        req = 1'b0; we = 1'b0;
        checks++; if (nacks != 1)      begin errors++; $display("FAIL cap_acks got=%0d exp=1", nacks); end
        checks++; if (got !== model[9]) begin errors++; $display("FAIL cap_rdata got=%h exp=%h", got, model[9]); end
        txn(1'b0, 6'd10, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== model[10]) begin errors++; $display("FAIL cap_nowrite got=%h exp=%h", rd, model[10]); end
    endtask

    task automatic test_held_req();
        int nacks; logic [31:0] got;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 6'd1;
        nacks = 0;
        repeat (10) begin @(negedge clk); if (ack) nacks++; end
        checks++; if (nacks != 1) begin errors++; $display("FAIL held_acks got=%0d exp=1", nacks); end
        req = 1'b0;
        @(negedge clk);
        req = 1'b1; nacks = 0; got = '0;
        repeat (8) begin @(negedge clk); if (ack) begin nacks++; got = rdata; end end
        req = 1'b0;
        checks++; if (nacks != 1) begin errors++; $display("FAIL rearm_acks got=%0d exp=1", nacks); end
        checks++; if (got !== model[1]) begin errors++; $display("FAIL rearm_rdata got=%h exp=%h", got, model[1]); end
        @(negedge clk);
    endtask

    task automatic test_req_drop_wait();
        int nacks, at; logic [31:0] got;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 6'd2;
        @(negedge clk);
        req = 1'b0;
        nacks = 0; at = -1; got = '0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (ack) begin nacks++; at = n; got = rdata; end
        end
        checks++; if (nacks != 1 || at != 2)
            begin errors++; $display("FAIL drop_ack got count=%0d at=%0d exp 1/2", nacks, at); end
        checks++; if (got !== model[2]) begin errors++; $display("FAIL drop_rdata got=%h exp=%h", got, model[2]); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, old; logic er; int lat; int nacks;
        old = model[7];
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 6'd7; wdata = ~old; be = 4'hF;
        @(negedge clk);
        #1 rst = 1'b1; req = 1'b0;
        #1;
        checks++; if (ack !== 1'b0 || rdata !== 32'h0)
            begin errors++; $display("FAIL rstmid_out got ack=%b rdata=%h exp 0/0", ack, rdata); end
        @(negedge clk);
        rst = 1'b0;
        nacks = 0;
        repeat (6) begin @(negedge clk); if (ack) nacks++; end
        checks++; if (nacks != 0) begin errors++; $display("FAIL rstmid_acks got=%0d exp=0", nacks); end
        txn(1'b0, 6'd7, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== old || lat != 3)
            begin errors++; $display("FAIL rstmid_read got=%h lat=%0d exp=%h/3", rd, lat, old); end
    endtask

    task automatic test_random();
        logic [31:0] rd, d, exp; logic er, w, experr; logic [5:0] a; logic [3:0] b; int lat;
        for (int i = 0; i < 150; i++) begin
            w = 1'($urandom); a = 6'($urandom_range(0, 55)); d = $urandom; b = 4'($urandom);
            exp = exp_rd(w, a); experr = (a >= DEPTH);
            txn(w, a, d, b, rd, er, lat);
            model_apply(w, a, d, b);
            checks++; if (rd !== exp || er !== experr || lat != 3)
                begin errors++; $display("FAIL rand i=%0d we=%b addr=%0d got rd=%h err=%b lat=%0d exp rd=%h err=%b lat=3",
                                         i, w, a, rd, er, lat, exp, experr); end
            @(negedge clk);
            checks++; if (ack !== 1'b0 || rdata !== 32'h0)
                begin errors++; $display("FAIL rand_idle i=%0d got ack=%b rdata=%h exp 0/0", i, ack, rdata); end
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd; logic er; int lat;
        txn0(1'b1, 6'd4, 32'h5A5AA5A5, 4'hF, rd, er, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL zw_wr_lat got=%0d exp=1", lat); end
        txn0(1'b0, 6'd4, 32'h0, 4'h0, rd, er, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL zw_rd_lat got=%0d exp=1", lat); end
        checks++; if (rd !== 32'h5A5AA5A5 || er !== 1'b0)
            begin errors++; $display("FAIL zw_rd got=%h err=%b exp=5a5aa5a5/0", rd, er); end
        txn0(1'b0, 6'd63, 32'h0, 4'h0, rd, er, lat);
        checks++; if (rd !== 32'h0 || er !== 1'b1 || lat != 1)
            begin errors++; $display("FAIL zw_oor got rd=%h err=%b lat=%0d exp 0/1/1", rd, er, lat); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_byte_enables();
        test_out_of_range();
        test_capture();
        test_held_req();
        test_req_drop_wait();
        test_reset_mid();
        test_random();
        test_zero_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
